// File: rtl/eth_pkt_pkg.sv
// Shared state encoding, header layout and beat geometry for the Ethernet AXIS
// packet generator.
package eth_pkt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_GAP
   } gen_state_t;

   localparam int DST_OFS     = 0;
   localparam int SRC_OFS     = 6;
   localparam int TYPE_OFS    = 12;
   localparam int PAYLOAD_OFS = 14;
   localparam int SEQ_LEN     = 4;

   localparam int BEAT_BYTES  = 8;
   localparam int DATA_W      = 8 * BEAT_BYTES;
   // 13 bits of beat index plus 3 lane bits span the full 16-bit length range.
   localparam int BEAT_IDX_W  = 13;

   typedef struct packed {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] ethertype;
   } eth_hdr_t;

   function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                             input logic [15:0] lo,
                                             input logic [15:0] hi);
      if (len < lo) return lo;
      if (len > hi) return hi;
      return len;
   endfunction

endpackage

// File: rtl/eth_pkt_beat_fmt.sv
// Combinational beat formatter: maps beat beat_idx of a frame onto the 8 AXIS lanes.
// Build option ETH_PKT_GEN_SEQNUM_EN inserts a 32-bit sequence number after the ethertype.
module eth_pkt_beat_fmt
   import eth_pkt_pkg::*;
(
   input  logic [BEAT_IDX_W-1:0] beat_idx,
   input  eth_hdr_t              hdr,
   input  logic [15:0]           len,
   input  logic [31:0]           seq,
   output logic [DATA_W-1:0]     tdata,
   output logic [BEAT_BYTES-1:0] tkeep,
   output logic                  tlast
);

`ifndef ETH_PKT_GEN_SEQNUM_EN
   logic unused_seq;
   assign unused_seq = ^seq;
`endif

   always_comb begin
      logic [BEAT_IDX_W+2:0] n;
      int                    k;
      logic [7:0]            b;
      // NOTE: every output gets a default before the loop so no path leaves
      // a bit unassigned, which would otherwise infer a latch.
      tdata = '0;
      tkeep = '0;
      n     = '0;
      k     = 0;
      b     = '0;
      for (int l = 0; l < BEAT_BYTES; l++) begin
         n = {beat_idx, 3'(l)};
         k = int'(n);
         if (k < SRC_OFS)
            b = hdr.dst[8*(SRC_OFS-1-(k-DST_OFS)) +: 8];
         else if (k < TYPE_OFS)
            b = hdr.src[8*(TYPE_OFS-1-k) +: 8];
         else if (k < PAYLOAD_OFS)
            b = hdr.ethertype[8*(PAYLOAD_OFS-1-k) +: 8];
`ifdef ETH_PKT_GEN_SEQNUM_EN
         else if (k < PAYLOAD_OFS + SEQ_LEN)
            b = seq[8*(PAYLOAD_OFS+SEQ_LEN-1-k) +: 8];
         else
            b = 8'(k - PAYLOAD_OFS - SEQ_LEN);
`else
         else
            b = 8'(k - PAYLOAD_OFS);
`endif
         // Lanes past the end of the frame stay zero with their keep bit clear.
         if (n < len) begin
            tdata[8*l +: 8] = b;
            tkeep[l]        = 1'b1;
         end
      end
      tlast = (beat_idx == BEAT_IDX_W'((len - 16'd1) >> 3));
   end

endmodule

// File: rtl/eth_axis_pkt_gen.sv
// Ethernet test-frame generator driving a 64-bit AXIS stream toward the MAC TX FIFO.
// Build option ETH_PKT_GEN_SEQNUM_EN adds a per-burst frame sequence number to the payload.
module eth_axis_pkt_gen
   import eth_pkt_pkg::*;
#(
   parameter int MAX_FRAME_LEN = 9014,
   parameter int MIN_FRAME_LEN = 60
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  stop,
   input  logic [15:0]           frame_len,
   input  logic [31:0]           frame_count,
   input  logic [47:0]           dst_mac,
   input  logic [47:0]           src_mac,
   input  logic [15:0]           ethertype,
   input  logic [7:0]            gap_cycles,
   output logic [DATA_W-1:0]     tx_axis_tdata,
   output logic [BEAT_BYTES-1:0] tx_axis_tkeep,
   output logic                  tx_axis_tvalid,
   output logic                  tx_axis_tlast,
   output logic                  tx_axis_tuser,
   input  logic                  tx_axis_tready,
   output logic                  busy,
   output logic [31:0]           sent_count
);

   gen_state_t             state;
   eth_hdr_t               hdr_q, fmt_hdr;
   logic [15:0]            len_q, fmt_len;
   logic [31:0]            count_q, seq_q, fmt_seq;
   logic [7:0]             gap_q, gap_cnt;
   logic [BEAT_IDX_W-1:0]  beat_q, fmt_beat;
   logic                   stop_q;
   logic [DATA_W-1:0]      fmt_data;
   logic [BEAT_BYTES-1:0]  fmt_keep;
   logic                   fmt_last;
   logic                   hs, stop_now, count_done, gap_done;

   assign hs            = tx_axis_tvalid && tx_axis_tready;
   assign stop_now      = stop_q || stop;
   assign count_done    = (count_q != 32'd0) && (sent_count + 32'd1 == count_q);
   assign gap_done      = (count_q != 32'd0) && (sent_count == count_q);
   assign busy          = (state != ST_IDLE);
   assign tx_axis_tuser = 1'b0;

   // Select the beat to be loaded on the next edge: live inputs while idle so
   // the first beat is valid one cycle after start, latched config otherwise.
   always_comb begin
      fmt_hdr  = hdr_q;
      fmt_len  = len_q;
      fmt_seq  = seq_q;
      fmt_beat = '0;
      unique case (state)
         ST_IDLE: begin
            fmt_hdr = '{dst: dst_mac, src: src_mac, ethertype: ethertype};
            fmt_len = clamp_len(frame_len, 16'(MIN_FRAME_LEN), 16'(MAX_FRAME_LEN));
            fmt_seq = '0;
         end
         ST_DATA: begin
            if (tx_axis_tlast) fmt_seq  = seq_q + 32'd1;
            else               fmt_beat = beat_q + BEAT_IDX_W'(1);
         end
         default: ;
      endcase
   end

   eth_pkt_beat_fmt u_beat_fmt (
      .beat_idx (fmt_beat),
      .hdr      (fmt_hdr),
      .len      (fmt_len),
      .seq      (fmt_seq),
      .tdata    (fmt_data),
      .tkeep    (fmt_keep),
      .tlast    (fmt_last)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= ST_IDLE;
         hdr_q          <= '0;
         len_q          <= '0;
         count_q        <= '0;
         gap_q          <= '0;
         gap_cnt        <= '0;
         beat_q         <= '0;
         seq_q          <= '0;
         stop_q         <= 1'b0;
         sent_count     <= '0;
         tx_axis_tdata  <= '0;
         tx_axis_tkeep  <= '0;
         tx_axis_tvalid <= 1'b0;
         tx_axis_tlast  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads the
         // pre-edge register values regardless of statement order.
         if (state != ST_IDLE && stop) stop_q <= 1'b1;
         unique case (state)
            ST_IDLE: begin
               stop_q <= 1'b0;
               if (start) begin
                  hdr_q          <= fmt_hdr;
                  len_q          <= fmt_len;
                  count_q        <= frame_count;
                  gap_q          <= gap_cycles;
                  sent_count     <= '0;
                  seq_q          <= '0;
                  beat_q         <= '0;
                  tx_axis_tdata  <= fmt_data;
                  tx_axis_tkeep  <= fmt_keep;
                  tx_axis_tlast  <= fmt_last;
                  tx_axis_tvalid <= 1'b1;
                  state          <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (hs) begin
                  tx_axis_tdata <= fmt_data;
                  tx_axis_tkeep <= fmt_keep;
                  tx_axis_tlast <= fmt_last;
                  beat_q        <= fmt_beat;
                  if (tx_axis_tlast) begin
                     sent_count <= sent_count + 32'd1;
                     seq_q      <= fmt_seq;
                     if (gap_q != 8'd0) begin
                        gap_cnt        <= gap_q;
                        tx_axis_tvalid <= 1'b0;
                        state          <= ST_GAP;
                     end else if (count_done || stop_now) begin
                        tx_axis_tvalid <= 1'b0;
                        state          <= ST_IDLE;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (stop_now || (gap_cnt == 8'd1 && gap_done)) begin
                  state <= ST_IDLE;
               end else if (gap_cnt == 8'd1) begin
                  tx_axis_tdata  <= fmt_data;
                  tx_axis_tkeep  <= fmt_keep;
                  tx_axis_tlast  <= fmt_last;
                  tx_axis_tvalid <= 1'b1;
                  state          <= ST_DATA;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/eth_axis_pkt_gen.md
ETH_AXIS_PKT_GEN -- requirements
Module: eth_axis_pkt_gen

Interface
REQ-001 SHALL have parameter MAX_FRAME_LEN, default 9014, largest generated frame in bytes excluding FCS.
REQ-002 SHALL have parameter MIN_FRAME_LEN, default 60, smallest generated frame in bytes excluding FCS.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; ports `clock` (input, 1) and `resetn` (input, 1), listed first.
REQ-004 start  input  1  pulse; latch configuration and begin a burst.
REQ-005 stop  input  1  pulse; end the burst after the current frame.
REQ-006 frame_len  input  16  frame length in bytes, excluding FCS.
REQ-007 frame_count  input  32  frames per burst; 0 = continuous.
REQ-008 dst_mac, src_mac  input  48 each  header addresses.
REQ-009 ethertype  input  16  header type field.
REQ-010 gap_cycles  input  8  idle cycles between frames.
REQ-011 tx_axis_tdata/tkeep/tvalid/tlast/tuser  output  64/8/1/1/1  AXIS source toward the MAC TX FIFO.
REQ-012 tx_axis_tready  input  1  AXIS ready.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 sent_count  output  32  frames fully accepted since the last start; wraps at 2^32.

Function
REQ-015 SHALL implement FSM states IDLE, DATA and GAP.
REQ-016 IDLE->DATA SHALL occur on start; on that edge latch all configuration inputs, clear sent_count and clear the sequence number.
REQ-017 start while busy SHALL be ignored.
REQ-018 Latched length SHALL be clamped to [MIN_FRAME_LEN, MAX_FRAME_LEN].
REQ-019 Byte n of a frame SHALL occupy beat n/8, lane n%8 (tdata[8*(n%8)+:8]).
REQ-020 Bytes 0-5 SHALL carry dst_mac MSB first, bytes 6-11 src_mac MSB first, bytes 12-13 ethertype MSB first.
REQ-021 Each payload byte n>=14 SHALL equal (n-14) mod 256.
REQ-022 A frame SHALL be ceil(L/8) beats; tlast SHALL be on the final beat only.
REQ-023 tkeep SHALL be 8'hFF on all non-final beats; on the final beat tkeep = (1<<(L%8))-1, or 8'hFF when L%8=0; unused lanes SHALL be zero.
REQ-024 tuser SHALL be constantly 0.
REQ-025 tvalid SHALL be high throughout DATA with no bubbles; the first beat SHALL be valid on the cycle after start.
REQ-026 While tvalid && !tready, tdata/tkeep/tlast SHALL hold stable.
REQ-027 Final-beat handshake SHALL increment sent_count in the same edge, then go to GAP; if gap_cycles=0, go directly to DATA or IDLE.
REQ-028 GAP SHALL last exactly gap_cycles cycles with tvalid low, then go to DATA unless the burst is done.
REQ-029 The burst is done when sent_count reaches a nonzero frame_count, or when stop has been seen; done goes to IDLE.
REQ-030 stop SHALL be sticky until IDLE; stop in DATA completes the current frame and never truncates it; stop in GAP goes to IDLE on the next edge.
REQ-031 stop and start in the same cycle while IDLE SHALL start the burst; the stop is ignored.

Reset
REQ-032 resetn low SHALL asynchronously force IDLE, tvalid=0, tlast=0, tdata=0, tkeep=0, busy=0, sent_count=0 and clear the sticky stop and sequence number.
REQ-033 Reset mid-frame SHALL abandon the frame with no tlast emitted; the downstream FIFO handles the truncation.

Configuration
REQ-034 Macro ETH_PKT_GEN_SEQNUM_EN defined: bytes 14-17 SHALL carry a 32-bit per-burst frame sequence number, MSB first, starting at 0 and incrementing per frame; the pattern then restarts at byte 18 as (n-18) mod 256.
REQ-035 ETH_PKT_GEN_SEQNUM_EN undefined: no sequence field; REQ-021 applies from byte 14.

Structure
REQ-036 State enum, header byte offsets (DST=0, SRC=6, TYPE=12, PAYLOAD=14, SEQ_LEN=4) and beat width SHALL live in shared package eth_pkt_pkg.
REQ-037 SHALL contain one sub-module, eth_pkt_beat_fmt: a combinational beat formatter taking beat index, latched header, length and sequence number, and returning tdata/tkeep/tlast.

Verification
REQ-038 len=60, count=1, gap=0, tready=1 -> 8 beats in cycles 1-8; beat 7 tkeep=8'h0F, tlast=1; sent_count=1; busy drops after the last beat.
REQ-039 len=64, count=3, gap=5 -> 3 frames, each final beat tkeep=8'hFF; exactly 5 idle cycles between frames; sent_count=3.
REQ-040 len=20 (clamped to 60), with tready toggling 1-0-1-0 -> 60 bytes delivered; data stable during each stall; byte 14=0x00 and byte 59=0x2D (SEQNUM off).
REQ-041 count=0, stop asserted at beat 3 of frame 5 -> frame 5 completes intact, then IDLE; sent_count=5.
REQ-042 SEQNUM on, count=2 -> frame 0 bytes 14-17 = 00 00 00 00; frame 1 bytes 14-17 = 00 00 00 01; byte 18 = 0x00.
REQ-043 resetn low at beat 4 of a frame -> tvalid=0 the same cycle (async); after release the block is IDLE and a new start produces a correct frame.
